// File: rtl/mem_addr_stepper_if.sv
// Bundles the push-button inputs, timebase and address outputs of the memory-view
// address stepper. The top-level or board logic is master; the stepper is slave.
interface mem_addr_stepper_if #(
  parameter int ADDR_W = 10
);
  logic              tick;
  logic              enable;
  logic              addrI;
  logic              addrD;
  logic [ADDR_W-1:0] memAddr;
  logic              step;
  logic              busy;

  modport master (
    output tick, enable, addrI, addrD,
    input  memAddr, step, busy
  );

  modport slave (
    input  tick, enable, addrI, addrD,
    output memAddr, step, busy
  );
endinterface

// File: rtl/mem_addr_stepper.sv
// Debounced, auto-repeating increment/decrement of the memory inspection address
// driven from two raw push-buttons, with wrap-around at 0 and ADDR_MAX.
module mem_addr_stepper #(
  parameter int ADDR_W         = 10,
  parameter int ADDR_MAX       = 1023,
  parameter int DEBOUNCE_TICKS = 8,
  parameter int REPEAT_DELAY   = 200,
  parameter int REPEAT_PERIOD  = 20,
  parameter int CNT_W          = 8
) (
  input  logic                clk,
  input  logic                rst,
  mem_addr_stepper_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_DB,
    HELD,
    REPEAT,
    RELEASE_DB
  } state_t;

  localparam logic [CNT_W-1:0]  DB_LAST  = CNT_W'(DEBOUNCE_TICKS - 1);
  localparam logic [CNT_W-1:0]  DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0]  PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [ADDR_W-1:0] TOP_ADDR = ADDR_W'(ADDR_MAX);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              dir_reg, dir_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic              step_reg, step_next;
  logic              inc_meta_reg, inc_s_reg;
  logic              dec_meta_reg, dec_s_reg;

  logic              req, same, quiet, do_step;
  logic [ADDR_W-1:0] addr_stepped;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inc_meta_reg <= 1'b0;
      inc_s_reg    <= 1'b0;
      dec_meta_reg <= 1'b0;
      dec_s_reg    <= 1'b0;
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      dir_reg      <= 1'b0;
      addr_reg     <= '0;
      step_reg     <= 1'b0;
    end else begin
      inc_meta_reg <= bus.addrI;
      inc_s_reg    <= inc_meta_reg;
      dec_meta_reg <= bus.addrD;
      dec_s_reg    <= dec_meta_reg;
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      dir_reg      <= dir_next;
      addr_reg     <= addr_next;
      step_reg     <= step_next;
    end
  end

  // Pressing both buttons together is treated as no request at all.
  assign req   = inc_s_reg ^ dec_s_reg;
  assign same  = req & (inc_s_reg == dir_reg);
  assign quiet = ~inc_s_reg & ~dec_s_reg;

  always_comb begin
    if (dir_reg)
      addr_stepped = (addr_reg == TOP_ADDR) ? '0 : addr_reg + ADDR_W'(1);
    else
      addr_stepped = (addr_reg == '0) ? TOP_ADDR : addr_reg - ADDR_W'(1);
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    dir_next   = dir_reg;
    do_step    = 1'b0;

    if (!bus.enable) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      // Exit conditions are evaluated every clock and take precedence over a tick.
      unique case (state_reg)
        IDLE: begin
          if (req) begin
            state_next = PRESS_DB;
            cnt_next   = '0;
            dir_next   = inc_s_reg;
          end
        end
        PRESS_DB: begin
          if (!same) begin
            state_next = IDLE;
          end else if (bus.tick) begin
            if (cnt_reg == DB_LAST) begin
              do_step    = 1'b1;
              state_next = HELD;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt_reg + CNT_W'(1);
            end
          end
        end
        HELD: begin
          if (!same) begin
            state_next = RELEASE_DB;
            cnt_next   = '0;
          end else if (bus.tick) begin
            if (cnt_reg == DLY_LAST) begin
              do_step    = 1'b1;
              state_next = REPEAT;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt_reg + CNT_W'(1);
            end
          end
        end
        REPEAT: begin
          if (!same) begin
            state_next = RELEASE_DB;
            cnt_next   = '0;
          end else if (bus.tick) begin
            if (cnt_reg == PER_LAST) begin
              do_step  = 1'b1;
              cnt_next = '0;
            end else begin
              cnt_next = cnt_reg + CNT_W'(1);
            end
          end
        end
        RELEASE_DB: begin
          if (!quiet) begin
            cnt_next = '0;
          end else if (bus.tick) begin
            if (cnt_reg == DB_LAST)
              state_next = IDLE;
            else
              cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  always_comb begin
    step_next = do_step;
    if (!bus.enable)
      addr_next = '0;
    else if (do_step)
      addr_next = addr_stepped;
    else
      addr_next = addr_reg;
  end

  assign bus.memAddr = addr_reg;
  assign bus.step    = step_reg;
  assign bus.busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_mem_addr_stepper.sv
// Scoreboard bench for mem_addr_stepper: each expected step (address and tick index
// since PRESS_DB entry) is queued when a press is driven and popped on every step pulse.
module tb_mem_addr_stepper;

  localparam int AW   = 4;
  localparam int AMAX = 11;

  typedef struct {
    int addr;
    int tidx;
  } exp_t;

  logic clk;
  logic rst;
  mem_addr_stepper_if #(.ADDR_W(AW)) bus ();

  mem_addr_stepper #(
    .ADDR_W(AW), .ADDR_MAX(AMAX), .DEBOUNCE_TICKS(2),
    .REPEAT_DELAY(4), .REPEAT_PERIOD(2), .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  exp_t sb_q[$];
  int   chk_cnt    = 0;
  int   err_cnt    = 0;
  int   exp_addr   = 0;
  int   tick_count = 0;
  int   entry_tick = 0;
  bit   busy_prev  = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Tick every 4 clocks, driven on the falling edge.
  initial begin
    int phase;
    phase    = 0;
    bus.tick = 1'b0;
    forever begin
      @(negedge clk);
      phase    = (phase + 1) % 4;
      bus.tick = (phase == 0);
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      if (bus.tick === 1'b1) tick_count++;
    end
  end

  // Monitor: a rising busy marks PRESS_DB entry; each step pulse pops the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_prev = 1'b0;
      end else begin
        if (bus.busy && !busy_prev) entry_tick = tick_count;
        busy_prev = bus.busy;
        if (bus.step) begin
          $display("step: memAddr=%0d tick_idx=%0d t=%0t", bus.memAddr, tick_count - entry_tick, $time);
          if (sb_q.size() == 0) begin
            check("unexpected_step", 1, 0);
          end else begin
            e = sb_q.pop_front();
            check("step_addr", int'(bus.memAddr), e.addr);
            check("step_tick", tick_count - entry_tick, e.tidx);
          end
        end
      end
    end
  end

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (bus.tick !== 1'b1) @(posedge clk);
    end
  endtask

  task automatic push_step(input bit up, input int tidx);
    if (up) exp_addr = (exp_addr == AMAX) ? 0 : exp_addr + 1;
    else    exp_addr = (exp_addr == 0) ? AMAX : exp_addr - 1;
    sb_q.push_back('{addr: exp_addr, tidx: tidx});
  endtask

  task automatic end_checks(input string tag);
    check({tag, "_pending"}, sb_q.size(), 0);
    check({tag, "_addr"}, int'(bus.memAddr), exp_addr);
    check({tag, "_busy"}, int'(bus.busy), 0);
  endtask

  // Press one button for 3 ticks, release, then follow the release debounce.
  task automatic single_press(input bit up, input bit expect_step, input string tag);
    wait_ticks(1);
    @(negedge clk);
    if (up) bus.addrI = 1'b1; else bus.addrD = 1'b1;
    if (expect_step) push_step(up, 2);
    wait_ticks(3);
    @(negedge clk);
    bus.addrI = 1'b0;
    bus.addrD = 1'b0;
    wait_ticks(1);
    @(negedge clk);
    check({tag, "_busy_rel"}, int'(bus.busy), int'(expect_step));
    wait_ticks(1);
    @(negedge clk);
    check({tag, "_busy_idle"}, int'(bus.busy), 0);
    wait_ticks(1);
    @(negedge clk);
    end_checks(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    bus.enable = 1'b1;
    bus.addrI  = 1'b0;
    bus.addrD  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_addr", int'(bus.memAddr), 0);
    check("rst_step", int'(bus.step), 0);
    check("rst_busy", int'(bus.busy), 0);
    rst = 1'b0;

    // Bounce: addrI toggles every clock for 10 clocks.
    wait_ticks(1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.addrI = ~bus.addrI;
    end
    wait_ticks(3);
    @(negedge clk);
    end_checks("bounce");

    single_press(1'b1, 1'b1, "clean");

    // Enable low clears the address and ignores presses.
    @(negedge clk);
    bus.enable = 1'b0;
    @(negedge clk);
    exp_addr = 0;
    check("en_clear_addr", int'(bus.memAddr), 0);
    single_press(1'b1, 1'b0, "en_low");
    @(negedge clk);
    bus.enable = 1'b1;

    single_press(1'b0, 1'b1, "wrap_dec");
    single_press(1'b1, 1'b1, "wrap_inc");

    // Auto-repeat: hold addrI for 20 ticks from PRESS_DB entry.
    wait_ticks(1);
    @(negedge clk);
    bus.addrI = 1'b1;
    push_step(1'b1, 2);
    for (int t = 6; t <= 20; t += 2) push_step(1'b1, t);
    wait_ticks(20);
    @(negedge clk);
    bus.addrI = 1'b0;
    wait_ticks(3);
    @(negedge clk);
    end_checks("repeat");
    check("repeat_final", int'(bus.memAddr), 9);

    // Both buttons held: never leaves IDLE.
    wait_ticks(1);
    @(negedge clk);
    bus.addrI = 1'b1;
    bus.addrD = 1'b1;
    wait_ticks(5);
    @(negedge clk);
    check("both_busy", int'(bus.busy), 0);
    wait_ticks(5);
    @(negedge clk);
    bus.addrI = 1'b0;
    bus.addrD = 1'b0;
    wait_ticks(2);
    @(negedge clk);
    end_checks("both");

    // Direction change without a gap: one increment only.
    wait_ticks(1);
    @(negedge clk);
    bus.addrI = 1'b1;
    push_step(1'b1, 2);
    wait_ticks(3);
    @(negedge clk);
    bus.addrI = 1'b0;
    bus.addrD = 1'b1;
    wait_ticks(10);
    @(negedge clk);
    check("swap_busy_held", int'(bus.busy), 1);
    bus.addrD = 1'b0;
    wait_ticks(4);
    @(negedge clk);
    end_checks("swap");
    single_press(1'b0, 1'b1, "after_swap");

    // Async reset mid-REPEAT, button still held afterwards.
    wait_ticks(1);
    @(negedge clk);
    bus.addrI = 1'b1;
    push_step(1'b1, 2);
    push_step(1'b1, 6);
    push_step(1'b1, 8);
    wait_ticks(8);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_addr", int'(bus.memAddr), 0);
    check("arst_busy", int'(bus.busy), 0);
    check("arst_step", int'(bus.step), 0);
    check("arst_pending", sb_q.size(), 0);
    exp_addr = 0;
    @(negedge clk);
    #2;
    rst = 1'b0;
    push_step(1'b1, 2);
    wait_ticks(4);
    @(negedge clk);
    bus.addrI = 1'b0;
    wait_ticks(4);
    @(negedge clk);
    end_checks("arst_restart");

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
